// File: rtl/host_tx_descriptor_process.sv
// Host TX descriptor processor: fetches packet lines for a bufid,
// emits them as flagged host-port words, then releases the bufid.
module host_tx_descriptor_process #(
    parameter int RAM_RD_LATENCY = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [21:0]  iv_descriptor,
    input  logic         i_descriptor_wr,
    output logic         o_descriptor_ready,
    output logic [15:0]  ov_ram_raddr,
    output logic         o_ram_rd,
    input  logic [127:0] iv_ram_rdata,
    output logic [133:0] ov_data,
    output logic         o_data_wr,
    input  logic         i_host_fifo_alf,
    output logic [8:0]   ov_bufid,
    output logic         o_bufid_release,
    output logic         o_err_busy_wr
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        RELEASE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [8:0]                r_bufid;
    logic [1:0]                r_type;
    logic [7:0]                r_lines;
    logic [3:0]                r_inval;
    logic [7:0]                r_rd_line;
    logic [7:0]                r_out_line;
    logic [RAM_RD_LATENCY-1:0] r_vld;
    logic                      r_ready;
    logic                      r_release;
    logic [8:0]                r_rel_bufid;
    logic                      r_busy;

    logic [10:0] w_len;
    logic [7:0]  w_lines_in;
    logic [3:0]  w_inval_in;
    logic        w_accept;
    logic        w_rd;
    logic        w_last_rd;
    logic        w_dv;
    logic        w_first_out;
    logic        w_last_out;
    logic [1:0]  w_unused_type;

    assign w_len       = iv_descriptor[19:9];
    assign w_lines_in  = 8'((12'(w_len) + 12'd15) >> 4);
    assign w_inval_in  = 4'(4'd0 - w_len[3:0]);
    // The cycle carrying the ready pulse is still busy for the upstream.
    assign w_accept    = i_descriptor_wr && (r_state == IDLE) && !r_ready;
    assign w_rd        = (r_state == READ) && !i_host_fifo_alf;
    assign w_last_rd   = w_rd && (r_rd_line == r_lines - 8'd1);
    assign w_dv        = r_vld[RAM_RD_LATENCY-1];
    assign w_first_out = (r_out_line == 8'd0);
    assign w_last_out  = (r_out_line == r_lines - 8'd1);
    assign w_unused_type = r_type;

    assign ov_ram_raddr       = {r_bufid, r_rd_line[6:0]};
    assign o_ram_rd           = w_rd;
    assign o_data_wr          = w_dv;
    assign ov_data            = w_dv ? {w_last_out, w_first_out,
                                        w_last_out ? r_inval : 4'd0,
                                        iv_ram_rdata} : '0;
    assign o_descriptor_ready = r_ready;
    assign o_bufid_release    = r_release;
    assign ov_bufid           = r_rel_bufid;
    assign o_err_busy_wr      = r_busy;

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (w_len != 11'd0) ? READ : RELEASE;
                end
            end
            READ: begin
                if (w_last_rd) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_dv && w_last_out) begin
                    w_next = RELEASE;
                end
            end
            RELEASE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Descriptor capture, line counters and read-return tracking
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_bufid    <= '0;
            r_type     <= '0;
            r_lines    <= '0;
            r_inval    <= '0;
            r_rd_line  <= '0;
            r_out_line <= '0;
            r_vld      <= '0;
        end else begin
            if (w_accept) begin
                r_bufid    <= iv_descriptor[8:0];
                r_type     <= iv_descriptor[21:20];
                r_lines    <= w_lines_in;
                r_inval    <= w_inval_in;
                r_rd_line  <= '0;
                r_out_line <= '0;
            end else begin
                if (w_rd) begin
                    r_rd_line <= r_rd_line + 8'd1;
                end
                if (w_dv) begin
                    r_out_line <= r_out_line + 8'd1;
                end
            end
            for (int i = RAM_RD_LATENCY - 1; i > 0; i--) begin
                r_vld[i] <= r_vld[i-1];
            end
            r_vld[0] <= w_rd;
        end
    end

    // Release/ready pulses and busy-write error flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ready     <= 1'b0;
            r_release   <= 1'b0;
            r_rel_bufid <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_ready     <= (r_state == RELEASE);
            r_release   <= (r_state == RELEASE);
            r_rel_bufid <= (r_state == RELEASE) ? r_bufid : 9'd0;
            r_busy      <= i_descriptor_wr && !w_accept;
        end
    end

endmodule

// File: tb/tb_host_tx_descriptor_process.sv
// Scoreboard bench for host_tx_descriptor_process with a behavioural
// RAM and an expected-output queue per output channel.
module tb_host_tx_descriptor_process;

    localparam int L = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [21:0]  desc = '0;
    logic         wr = 1'b0;
    logic         alf = 1'b0;
    logic [127:0] rdata;

    logic         o_ready;
    logic [15:0]  o_raddr;
    logic         o_rd;
    logic [133:0] o_data;
    logic         o_dwr;
    logic [8:0]   o_bufid;
    logic         o_rel;
    logic         o_busy;

    int errors = 0;
    int checks = 0;

    logic [15:0]  q_addr[$];
    logic [133:0] q_data[$];
    logic [8:0]   q_rel[$];

    host_tx_descriptor_process #(.RAM_RD_LATENCY(L)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .iv_descriptor      (desc),
        .i_descriptor_wr    (wr),
        .o_descriptor_ready (o_ready),
        .ov_ram_raddr       (o_raddr),
        .o_ram_rd           (o_rd),
        .iv_ram_rdata       (rdata),
        .ov_data            (o_data),
        .o_data_wr          (o_dwr),
        .i_host_fifo_alf    (alf),
        .ov_bufid           (o_bufid),
        .o_bufid_release    (o_rel),
        .o_err_busy_wr      (o_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] ram_word(input logic [15:0] a);
        logic [15:0] b;
        b = a * 16'd3 + 16'd1;
        return {4{b, a}};
    endfunction

    // Behavioural RAM: data for an address read appears L cycles later
    logic        pv[L];
    logic [15:0] pa[L];
    always @(posedge clk) begin
        pv[0] <= o_rd;
        pa[0] <= o_raddr;
        for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end
    assign rdata = (pv[L-1] === 1'b1) ? ram_word(pa[L-1])
                                      : {4{32'hDEADBEEF}};

    task automatic chk(input string nm, input logic [133:0] act,
                       input logic [133:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event", nm);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"}, 134'(o_ready), 134'd0);
        chk({tag, "_raddr"}, 134'(o_raddr), 134'd0);
        chk({tag, "_rd"},    134'(o_rd),    134'd0);
        chk({tag, "_data"},  o_data,        134'd0);
        chk({tag, "_dwr"},   134'(o_dwr),   134'd0);
        chk({tag, "_bufid"}, 134'(o_bufid), 134'd0);
        chk({tag, "_rel"},   134'(o_rel),   134'd0);
        chk({tag, "_busy"},  134'(o_busy),  134'd0);
    endtask

    // Reference model: what a descriptor must produce, from len alone
    task automatic expect_pkt(input logic [8:0] b, input int len);
        int lines;
        logic [15:0] a;
        logic [1:0]  fl;
        logic [3:0]  inv;
        lines = (len + 15) / 16;
        for (int i = 0; i < lines; i++) begin
            a   = {b, 7'(i)};
            fl  = {i == lines - 1, i == 0};
            inv = (i == lines - 1) ? 4'(lines * 16 - len) : 4'd0;
            q_addr.push_back(a);
            q_data.push_back({fl, inv, ram_word(a)});
        end
        q_rel.push_back(b);
    endtask

    // Monitor: every DUT output event must match the head of its queue
    always @(negedge clk) begin
        logic [15:0]  ea;
        logic [133:0] ed;
        logic [8:0]   eb;
        if (o_rd) begin
            if (q_addr.size() == 0) bad("unexpected_rd");
            else begin
                ea = q_addr.pop_front();
                chk("raddr", 134'(o_raddr), 134'(ea));
            end
        end
        if (o_dwr) begin
            if (q_data.size() == 0) bad("unexpected_data");
            else begin
                ed = q_data.pop_front();
                chk("data", o_data, ed);
            end
        end
        if (o_rel) begin
            if (q_rel.size() == 0) bad("unexpected_release");
            else begin
                eb = q_rel.pop_front();
                chk("rel_bufid", 134'(o_bufid), 134'(eb));
                chk("ready_with_rel", 134'(o_ready), 134'd1);
            end
        end
        if (o_ready && !o_rel) bad("ready_without_release");
    end

    // mode: 0 plain, 1 alf pause, 2 busy wr, 3 random alf,
    //       4 reset in drain, 5 wr on ready cycle
    task automatic send(input logic [8:0] b, input int len, input int mode);
        int n, rdcnt, alfcnt, lines, explat, gotlat;
        bit done;
        lines = (len + 15) / 16;
        explat = (len == 0) ? 2 : lines + L + 2;
        if (mode == 1) explat += 5;
        expect_pkt(b, len);
        @(posedge clk); #1;
        desc = {2'($urandom_range(0, 3)), 11'(len), b};
        wr = 1'b1;
        n = 0; rdcnt = 0; alfcnt = 0; done = 0; gotlat = -1;
        while (!done && n < 800) begin
            @(negedge clk);
            if (o_rd) rdcnt++;
            if (o_ready) begin
                done = 1;
                gotlat = n;
            end
            if ((mode == 0 || mode == 5) && len != 0 && n <= 1)
                chk("first_rd_timing", 134'(o_rd), 134'(n == 1));
            if (mode == 2 && (n == 3 || n == 4))
                chk("busy_pulse", 134'(o_busy), 134'(n == 3));
            if (!done) begin
                @(posedge clk); #1;
                n++;
                wr = 1'b0;
                if (mode == 2 && n == 2) begin
                    desc = {2'd1, 11'd48, 9'h0AA};
                    wr = 1'b1;
                end
                if (mode == 5 && n == explat) begin
                    desc = {2'd2, 11'd32, 9'h033};
                    wr = 1'b1;
                end
                if (mode == 1) begin
                    if (rdcnt >= 2 && alfcnt < 5) begin
                        alf = 1'b1;
                        alfcnt++;
                    end else alf = 1'b0;
                end
                if (mode == 3) alf = ($urandom_range(0, 3) == 0);
                if (mode == 4 && n == lines + 1) begin
                    rst_n = 1'b0;
                    @(posedge clk); #1;
                    q_addr.delete();
                    q_data.delete();
                    q_rel.delete();
                    rst_n = 1'b1;
                    @(negedge clk);
                    chk_zero("mid_reset");
                    repeat (12) @(negedge clk);
                    return;
                end
            end
        end
        alf = 1'b0;
        if (!done) bad("ready_timeout");
        if (mode <= 2 || mode == 5)
            chk("wr_to_ready", 134'(gotlat), 134'(explat));
        if (mode == 5) begin
            @(posedge clk); #1;
            wr = 1'b0;
        end
        @(negedge clk);
        chk("ready_one_cycle", 134'(o_ready), 134'd0);
        if (mode == 5) begin
            chk("busy_on_ready", 134'(o_busy), 134'd1);
            repeat (10) @(negedge clk);
        end
        chk("sb_drained", 134'(q_addr.size() + q_data.size() + q_rel.size()),
            134'd0);
    endtask

    initial begin
        int len;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        send(9'd5, 64, 0);
        send(9'h1FF, 65, 0);
        send(9'd7, 16, 0);
        send(9'd9, 0, 0);
        send(9'd12, 128, 1);
        send(9'd20, 128, 2);
        send(9'd33, 128, 4);
        send(9'd34, 40, 0);
        send(9'd40, 16, 5);
        send(9'd41, 2047, 0);
        send(9'd42, 2033, 3);
        send(9'd43, 1, 0);
        send(9'd44, 17, 0);

        for (int k = 0; k < 14; k++) begin
            len = $urandom_range(0, 600);
            send(9'($urandom_range(0, 511)), len, 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
